prog_launcher: RTL and testbench

PROG_LAUNCHER -- requirements
Module: prog_launcher

---
 rtl/prog_launcher_pkg.sv | 25 ++
 rtl/prog_launcher_if.sv | 40 ++++
 rtl/prog_launcher_sat_counter.sv | 25 ++
 rtl/prog_launcher.sv | 152 +++++++++++++++
 tb/tb_prog_launcher.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_launcher_pkg.sv
// Shared types and parameter defaults for the program launcher.
// Holds the launcher state encoding and a small state-classification helper.
// Imported by the interface, the top and the bench-facing parameters.
package prog_launcher_pkg;

  localparam int CW_DEF      = 16;
  localparam int RST_CYC_DEF = 2;
  localparam int PW_DEF      = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_DUT = 3'd1,
    START   = 3'd2,
    RUN     = 3'd3,
    RECORD  = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } launchStateT;

  // A run is in flight from DUT reset through the result capture.
  function automatic logic isBusy(input launchStateT s);
    return (s == RST_DUT) || (s == START) || (s == RUN) || (s == RECORD);
  endfunction

endpackage

// File: rtl/prog_launcher_if.sv
// Control/status bundle between a test controller and the program launcher.
// Latency: none, wires only.
// Backpressure: none; the launcher is a pure level/pulse protocol.
interface prog_launcher_if
  import prog_launcher_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int PW = PW_DEF
);

  logic          Go;
  logic          Abort;
  logic [PW-1:0] NumProgs;
  logic [CW-1:0] TimeoutLimit;
  logic          DutAck;
  logic          DutReset;
  logic          DutStart;
  logic [PW-1:0] ProgIdx;
  logic          Busy;
  logic          ResultValid;
  logic [CW-1:0] LastCycles;
  logic [CW+PW-1:0] TotalCycles;
  logic          Done;
  logic          Error;

  // Controller side: issues launch/abort and returns the processor ack.
  modport master (
    output Go, Abort, NumProgs, TimeoutLimit, DutAck,
    input  DutReset, DutStart, ProgIdx, Busy, ResultValid,
           LastCycles, TotalCycles, Done, Error
  );

  // Launcher side.
  modport slave (
    input  Go, Abort, NumProgs, TimeoutLimit, DutAck,
    output DutReset, DutStart, ProgIdx, Busy, ResultValid,
           LastCycles, TotalCycles, Done, Error
  );

endinterface

// File: rtl/prog_launcher_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: value updates one cycle after Clr/Inc are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Q
);

  // Count register: clear, then saturating increment.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Q <= '0;
    end else if (Clr) begin
      Q <= '0;
    end else if (Inc && (Q != '1)) begin
      Q <= Q + W'(1);
    end
  end

endmodule

// File: rtl/prog_launcher.sv
// Sequences a processor through reset, start and run for a list of programs, timing each one.
// Latency: all outputs registered; they follow the state they describe with no extra delay.
// Backpressure: none; Go is ignored while Busy, Abort forces IDLE on the next cycle.
module prog_launcher
  import prog_launcher_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int RST_CYC = RST_CYC_DEF,
  parameter int PW      = PW_DEF
) (
  input logic           Clk,
  input logic           Reset,
  prog_launcher_if.slave Bus
);

  // Wide enough to index 0..RST_CYC-1.
  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  launchStateT state;
  launchStateT stateNxt;

  logic [RCW-1:0]   rstCnt;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    numProgsQ;
  logic [CW-1:0]    limitQ;
  logic [PW-1:0]    progIdxQ;
  logic [CW-1:0]    lastQ;
  logic [CW+PW-1:0] totalQ;
  logic [CW+PW:0]   sumWide;
  logic [CW+PW-1:0] totalSat;
  logic             launch;
  logic             dutResetQ;
  logic             dutStartQ;
  logic             busyQ;
  logic             resultValidQ;
  logic             doneQ;
  logic             errorQ;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // Next-state decode; Abort overrides every other transition.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (Bus.Go) stateNxt = RST_DUT;
      end
      RST_DUT: begin
        if (rstCnt == RCW'(RST_CYC - 1)) stateNxt = START;
      end
      START: begin
        stateNxt = RUN;
      end
      RUN: begin
        // Ack on the limit cycle still counts as a completed program.
        if (Bus.DutAck) begin
          stateNxt = RECORD;
        end else if ((limitQ != '0) && (cnt == limitQ)) begin
          stateNxt = ERROR;
        end
      end
      RECORD: begin
        stateNxt = (progIdxQ == numProgsQ) ? DONE : START;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
    if (Bus.Abort) stateNxt = IDLE;
  end

  // Launch detect and saturating accumulation of the finished program's cycles.
  always_comb begin
    launch   = ((state == IDLE) || (state == DONE) || (state == ERROR)) && (stateNxt == RST_DUT);
    sumWide  = {1'b0, totalQ} + {{(PW + 1){1'b0}}, cnt};
    totalSat = sumWide[CW+PW] ? '1 : sumWide[CW+PW-1:0];
  end

  // Cleared on the way into START so the first RUN cycle reads 1; held during RECORD.
  sat_counter #(
    .W(CW)
  ) uRunCnt (
    .Clk  (Clk),
    .Reset(Reset),
    .Clr  (stateNxt == START),
    .Inc  (stateNxt == RUN),
    .Q    (cnt)
  );

  // Output and datapath registers, all decoded from the next state so they line up with it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rstCnt       <= '0;
      numProgsQ    <= '0;
      limitQ       <= '0;
      progIdxQ     <= '0;
      lastQ        <= '0;
      totalQ       <= '0;
      dutResetQ    <= 1'b1;
      dutStartQ    <= 1'b0;
      busyQ        <= 1'b0;
      resultValidQ <= 1'b0;
      doneQ        <= 1'b0;
      errorQ       <= 1'b0;
    end else begin
      dutResetQ    <= (stateNxt == IDLE) || (stateNxt == RST_DUT);
      dutStartQ    <= (stateNxt == START);
      busyQ        <= isBusy(stateNxt);
      resultValidQ <= (stateNxt == RECORD);
      doneQ        <= (stateNxt == DONE);
      errorQ       <= (stateNxt == ERROR);

      if (launch) begin
        rstCnt    <= '0;
        numProgsQ <= Bus.NumProgs;
        limitQ    <= Bus.TimeoutLimit;
        progIdxQ  <= '0;
        totalQ    <= '0;
      end else if (state == RST_DUT) begin
        rstCnt <= rstCnt + RCW'(1);
      end

      if (stateNxt == RECORD) begin
        lastQ  <= cnt;
        totalQ <= totalSat;
      end

      // The next program reuses the running processor; no re-reset.
      if ((state == RECORD) && (stateNxt == START)) begin
        progIdxQ <= progIdxQ + PW'(1);
      end
    end
  end

  assign Bus.DutReset    = dutResetQ;
  assign Bus.DutStart    = dutStartQ;
  assign Bus.ProgIdx     = progIdxQ;
  assign Bus.Busy        = busyQ;
  assign Bus.ResultValid = resultValidQ;
  assign Bus.LastCycles  = lastQ;
  assign Bus.TotalCycles = totalQ;
  assign Bus.Done        = doneQ;
  assign Bus.Error       = errorQ;

endmodule

// File: tb/tb_prog_launcher.sv
// Bench for prog_launcher: table of multi-program runs plus abort, reset and saturation sequences.
// Results are matched against a queue of expectations pushed when each DutAck is driven.
module tb_prog_launcher;

  localparam int CW      = 16;
  localparam int PW      = 2;
  localparam int RST_CYC = 2;

  typedef struct packed {
    logic [1:0]      np;
    logic [15:0]     lim;
    logic [3:0][7:0] dly;       // 0 = never ack
    logic            expDone;
    logic            expErr;
    logic [17:0]     expTotal;
    logic [2:0]      expStarts;
  } vecT;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] cyc;
    logic [17:0] tot;
  } expT;

  logic Clk;
  logic Reset;

  prog_launcher_if #(.CW(CW), .PW(PW)) b ();
  prog_launcher_if #(.CW(4), .PW(PW))  b4 ();

  prog_launcher #(.CW(CW), .RST_CYC(RST_CYC), .PW(PW)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Bus  (b)
  );

  prog_launcher #(.CW(4), .RST_CYC(RST_CYC), .PW(PW)) dut4 (
    .Clk  (Clk),
    .Reset(Reset),
    .Bus  (b4)
  );

  int  checks = 0;
  int  passes = 0;
  int  cyc = 0;
  int  startCnt = 0;
  int  rstHiCnt = 0;
  int  start4Cnt = 0;
  expT sbQ [$];
  vecT vecs [6];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] satTot(input logic [17:0] a, input int d);
    logic [18:0] s;
    s = {1'b0, a} + 19'(d);
    return s[18] ? 18'h3ffff : s[17:0];
  endfunction

  function automatic vecT mkVec(input int np, input int lim, input int d0, input int d1,
                                input int d2, input int d3, input bit dn, input bit er,
                                input int tot, input int st);
    vecT v;
    v.np        = 2'(np);
    v.lim       = 16'(lim);
    v.dly[0]    = 8'(d0);
    v.dly[1]    = 8'(d1);
    v.dly[2]    = 8'(d2);
    v.dly[3]    = 8'(d3);
    v.expDone   = dn;
    v.expErr    = er;
    v.expTotal  = 18'(tot);
    v.expStarts = 3'(st);
    return v;
  endfunction

  // Monitor: count pulses and score every result against the expectation queue.
  always @(negedge Clk) begin
    if (b.DutStart) startCnt++;
    if (b.DutReset && b.Busy) rstHiCnt++;
    if (b4.DutStart) start4Cnt++;
    if (b.ResultValid) begin
      if (sbQ.size() == 0) begin
        chk("unexpected ResultValid", 1, 0);
      end else begin
        expT e;
        e = sbQ.pop_front();
        chk("result ProgIdx", b.ProgIdx, e.idx);
        chk("result LastCycles", b.LastCycles, e.cyc);
        chk("result TotalCycles", b.TotalCycles, e.tot);
      end
    end
  end

  task automatic runRow(input int r, input vecT v);
    int          n;
    int          d;
    int          sCyc;
    int          startBase;
    int          rstBase;
    bit          timedOut;
    logic [17:0] runTot;
    runTot    = '0;
    timedOut  = 1'b0;
    sCyc      = 0;
    startBase = startCnt;
    rstBase   = rstHiCnt;
    b.NumProgs     = v.np;
    b.TimeoutLimit = v.lim;
    b.Go           = 1'b1;
    @(posedge Clk);
    #1 b.Go = 1'b0;
    @(negedge Clk);
    chk($sformatf("row%0d launch Busy", r), b.Busy, 1);
    chk($sformatf("row%0d launch Done", r), b.Done, 0);
    chk($sformatf("row%0d launch Error", r), b.Error, 0);
    chk($sformatf("row%0d launch TotalCycles", r), b.TotalCycles, 0);
    for (int i = 0; (i <= int'(v.np)) && !timedOut; i++) begin
      n = 0;
      while (!b.DutStart && (n < 200)) begin
        @(negedge Clk);
        n++;
      end
      if (!b.DutStart) begin
        chk($sformatf("row%0d prog%0d DutStart seen", r, i), 0, 1);
        return;
      end
      sCyc = cyc;
      d    = int'(v.dly[i]);
      if ((d == 0) || ((v.lim != 0) && (d > int'(v.lim)))) begin
        timedOut = 1'b1;
      end else begin
        runTot = satTot(runTot, d);
        sbQ.push_back('{idx: 2'(i), cyc: 16'(d), tot: runTot});
        repeat (d) @(posedge Clk);
        #1 b.DutAck = 1'b1;
        @(posedge Clk);
        #1 b.DutAck = 1'b0;
      end
    end
    n = 0;
    while (!b.Done && !b.Error && (n < 200)) begin
      @(negedge Clk);
      n++;
    end
    chk($sformatf("row%0d Done", r), b.Done, v.expDone);
    chk($sformatf("row%0d Error", r), b.Error, v.expErr);
    chk($sformatf("row%0d Busy", r), b.Busy, 0);
    chk($sformatf("row%0d TotalCycles", r), b.TotalCycles, v.expTotal);
    chk($sformatf("row%0d DutStart pulses", r), startCnt - startBase, v.expStarts);
    chk($sformatf("row%0d DutReset cycles", r), rstHiCnt - rstBase, RST_CYC);
    chk($sformatf("row%0d results drained", r), sbQ.size(), 0);
    if (timedOut) begin
      chk($sformatf("row%0d timeout latency", r), cyc - sCyc, int'(v.lim) + 1);
    end
  endtask

  task automatic waitStart(input string name);
    int n;
    n = 0;
    while (!b.DutStart && (n < 200)) begin
      @(negedge Clk);
      n++;
    end
    if (!b.DutStart) chk(name, 0, 1);
  endtask

  initial begin
    int n;
    Reset           = 1'b1;
    b.Go            = 1'b0;
    b.Abort         = 1'b0;
    b.NumProgs      = '0;
    b.TimeoutLimit  = '0;
    b.DutAck        = 1'b0;
    b4.Go           = 1'b0;
    b4.Abort        = 1'b0;
    b4.NumProgs     = '0;
    b4.TimeoutLimit = '0;
    b4.DutAck       = 1'b0;

    //               np lim  d0  d1  d2 d3 done err total starts
    vecs[0] = mkVec(0,  0, 37,  0,  0, 0, 1,   0,  37,   1);
    vecs[1] = mkVec(2,  0, 10, 20, 30, 0, 1,   0,  60,   3);
    vecs[2] = mkVec(0,  5,  0,  0,  0, 0, 0,   1,   0,   1);
    vecs[3] = mkVec(0,  5,  5,  0,  0, 0, 1,   0,   5,   1);
    vecs[4] = mkVec(1,  8,  8,  9,  0, 0, 0,   1,   8,   2);
    vecs[5] = mkVec(3,  0,  1,  2,  3, 4, 1,   0,  10,   4);

    // Reset state.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset DutReset", b.DutReset, 1);
    chk("reset DutStart", b.DutStart, 0);
    chk("reset Busy", b.Busy, 0);
    chk("reset ResultValid", b.ResultValid, 0);
    chk("reset Done", b.Done, 0);
    chk("reset Error", b.Error, 0);
    chk("reset ProgIdx", b.ProgIdx, 0);
    chk("reset LastCycles", b.LastCycles, 0);
    chk("reset TotalCycles", b.TotalCycles, 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("idle DutReset", b.DutReset, 1);

    for (int r = 0; r < 6; r++) runRow(r, vecs[r]);

    // Abort out of DONE clears Done.
    chk("pre-abort Done", b.Done, 1);
    b.Abort = 1'b1;
    @(posedge Clk);
    #1 b.Abort = 1'b0;
    @(negedge Clk);
    chk("abort from DONE Done", b.Done, 0);
    chk("abort from DONE DutReset", b.DutReset, 1);

    // Abort during RUN, colliding with DutAck: abort must win.
    b.NumProgs     = 2'd0;
    b.TimeoutLimit = 16'd0;
    b.Go           = 1'b1;
    @(posedge Clk);
    #1 b.Go = 1'b0;
    waitStart("abort run DutStart seen");
    repeat (3) @(posedge Clk);
    #1 b.Abort  = 1'b1;
    b.DutAck    = 1'b1;
    @(posedge Clk);
    #1 b.Abort  = 1'b0;
    b.DutAck    = 1'b0;
    @(negedge Clk);
    chk("abort run Busy", b.Busy, 0);
    chk("abort run DutReset", b.DutReset, 1);
    chk("abort run ResultValid", b.ResultValid, 0);
    chk("abort run Done", b.Done, 0);
    chk("abort run Error", b.Error, 0);
    repeat (5) @(negedge Clk);
    chk("abort run stays idle", b.Busy, 0);

    // Reset during RECORD of the first of two programs.
    b.NumProgs = 2'd1;
    b.Go       = 1'b1;
    @(posedge Clk);
    #1 b.Go = 1'b0;
    waitStart("reset rec DutStart seen");
    sbQ.push_back('{idx: 2'd0, cyc: 16'd4, tot: 18'd4});
    repeat (4) @(posedge Clk);
    #1 b.DutAck = 1'b1;
    @(posedge Clk);
    #1 b.DutAck = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    chk("record cycle ResultValid", b.ResultValid, 1);
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("reset rec DutReset", b.DutReset, 1);
    chk("reset rec Busy", b.Busy, 0);
    chk("reset rec ResultValid", b.ResultValid, 0);
    chk("reset rec DutStart", b.DutStart, 0);
    chk("reset rec Done", b.Done, 0);
    chk("reset rec Error", b.Error, 0);
    chk("reset rec TotalCycles", b.TotalCycles, 0);
    chk("reset rec LastCycles", b.LastCycles, 0);
    repeat (4) @(negedge Clk);
    chk("reset rec results drained", sbQ.size(), 0);

    // Narrow counter saturates; Go during RUN is ignored.
    b4.Go = 1'b1;
    @(posedge Clk);
    #1 b4.Go = 1'b0;
    n = 0;
    while (!b4.DutStart && (n < 200)) begin
      @(negedge Clk);
      n++;
    end
    chk("cw4 DutStart seen", b4.DutStart, 1);
    repeat (3) @(posedge Clk);
    #1 b4.Go = 1'b1;
    @(posedge Clk);
    #1 b4.Go = 1'b0;
    @(negedge Clk);
    chk("cw4 Go while busy Busy", b4.Busy, 1);
    chk("cw4 Go while busy DutReset", b4.DutReset, 0);
    chk("cw4 Go while busy DutStart", b4.DutStart, 0);
    repeat (16) @(posedge Clk);
    #1 b4.DutAck = 1'b1;
    @(posedge Clk);
    #1 b4.DutAck = 1'b0;
    chk("cw4 ResultValid", b4.ResultValid, 1);
    chk("cw4 LastCycles saturated", b4.LastCycles, 15);
    chk("cw4 TotalCycles", b4.TotalCycles, 15);
    @(negedge Clk);
    @(negedge Clk);
    chk("cw4 Done", b4.Done, 1);
    chk("cw4 Busy", b4.Busy, 0);
    chk("cw4 DutStart pulses", start4Cnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
